// File: rtl/div_result_bcd.sv
// Binary-to-BCD converter for the divider's quotient/remainder pair.
// Both operands are converted in lockstep with shift-and-add-3, one bit per cycle.
module div_result_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      quotient,
    input  logic [WIDTH-1:0]      remainder,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] q_bin;
    logic [WIDTH-1:0] r_bin;
    logic [BW-1:0]   q_acc;
    logic [BW-1:0]   r_acc;
    logic [BW-1:0]   q_acc_nxt;
    logic [BW-1:0]   r_acc_nxt;
    logic [CW-1:0]   cnt;
    logic            last_step;

    // One double-dabble step: adjust every digit >= 5, then shift in the next binary bit.
    function automatic logic [BW-1:0] dabble(input logic [BW-1:0] acc, input logic msb);
        logic [BW-1:0] adj;
        adj = acc;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
        return {adj[BW-2:0], msb};
    endfunction

    always_comb begin
        q_acc_nxt = dabble(q_acc, q_bin[WIDTH-1]);
        r_acc_nxt = dabble(r_acc, r_bin[WIDTH-1]);
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        last_step = (state == CONV) && (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CONV;
            CONV:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_bin     <= '0;
            r_bin     <= '0;
            q_acc     <= '0;
            r_acc     <= '0;
            cnt       <= '0;
            q_bcd     <= '0;
            r_bcd     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_bin <= quotient;
                        r_bin <= remainder;
                        q_acc <= '0;
                        r_acc <= '0;
                        cnt   <= '0;
                    end
                end
                CONV: begin
                    q_bin <= {q_bin[WIDTH-2:0], 1'b0};
                    r_bin <= {r_bin[WIDTH-2:0], 1'b0};
                    q_acc <= q_acc_nxt;
                    r_acc <= r_acc_nxt;
                    cnt   <= cnt + CW'(1);
                    // Final step publishes the freshly shifted value, not the stale accumulator.
                    if (last_step) begin
                        q_bcd     <= q_acc_nxt;
                        r_bcd     <= r_acc_nxt;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed, table-driven bench for div_result_bcd, plus handshake/reset corner sequences
// and a full sweep against a decimal reference.
module tb_div_result_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] q_bcd;
    logic [11:0] r_bcd;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int accept_cyc = 0;

    typedef struct {
        logic [7:0]  q;
        logic [7:0]  r;
        logic [11:0] eq;
        logic [11:0] er;
    } vec_t;

    vec_t vecs[10];

    div_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] b;
        b[11:8] = 4'(v / 100);
        b[7:4]  = 4'((v / 10) % 10);
        b[3:0]  = 4'(v % 10);
        return b;
    endfunction

    // Present a pair and hold it until accepted; returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] q, input logic [7:0] r);
        int n;
        n = 0;
        quotient  = q;
        remainder = r;
        in_valid  = 1'b1;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        accept_cyc = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", 32'(out_valid), 32'd1);
        lat = cyc - accept_cyc;
    endtask

    initial begin
        int lat;
        int a1;
        bit seen;

        rst = 1'b1; in_valid = 1'b0; quotient = '0; remainder = '0; out_ready = 1'b1;

        vecs[0] = '{8'd255, 8'd0,   12'h255, 12'h000};
        vecs[1] = '{8'd100, 8'd99,  12'h100, 12'h099};
        vecs[2] = '{8'd9,   8'd10,  12'h009, 12'h010};
        vecs[3] = '{8'd42,  8'd7,   12'h042, 12'h007};
        vecs[4] = '{8'd200, 8'd5,   12'h200, 12'h005};
        vecs[5] = '{8'd0,   8'd0,   12'h000, 12'h000};
        vecs[6] = '{8'd1,   8'd254, 12'h001, 12'h254};
        vecs[7] = '{8'd128, 8'd127, 12'h128, 12'h127};
        vecs[8] = '{8'd199, 8'd56,  12'h199, 12'h056};
        vecs[9] = '{8'd250, 8'd249, 12'h250, 12'h249};

        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q_bcd",     32'(q_bcd),     32'h0);
        check("rst_r_bcd",     32'(r_bcd),     32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].q, vecs[i].r);
            wait_out(lat);
            check($sformatf("vec%0d_latency", i), 32'(lat),   32'd8);
            check($sformatf("vec%0d_q", i),       32'(q_bcd), 32'(vecs[i].eq));
            check($sformatf("vec%0d_r", i),       32'(r_bcd), 32'(vecs[i].er));
            @(negedge clk);
            check($sformatf("vec%0d_release", i),  32'(out_valid), 32'd0);
            check($sformatf("vec%0d_idle", i),     32'(in_ready),  32'd1);
        end

        // Back-to-back transactions: second pair waits while the first sits in DONE.
        send(8'd100, 8'd99);
        wait_out(lat);
        a1 = accept_cyc;
        check("b2b_q1", 32'(q_bcd), 32'h100);
        check("b2b_r1", 32'(r_bcd), 32'h099);
        send(8'd9, 8'd10);
        check("b2b_ii", 32'(accept_cyc - a1), 32'd10);
        wait_out(lat);
        check("b2b_lat2", 32'(lat),   32'd8);
        check("b2b_q2",   32'(q_bcd), 32'h009);
        check("b2b_r2",   32'(r_bcd), 32'h010);
        @(negedge clk);

        // Backpressure, with stray in_valid pulses in CONV and DONE.
        out_ready = 1'b0;
        send(8'd42, 8'd7);
        in_valid = 1'b1; quotient = 8'd77; remainder = 8'd33;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        check("bp_latency", 32'(lat), 32'd8);
        in_valid = 1'b1; quotient = 8'd11; remainder = 8'd22;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold_valid%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold_q%0d", k),     32'(q_bcd),     32'h042);
            check($sformatf("bp_hold_r%0d", k),     32'(r_bcd),     32'h007);
            check($sformatf("bp_hold_ready%0d", k), 32'(in_ready),  32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready),  32'd1);
        check("bp_q_kept",        32'(q_bcd),     32'h042);
        check("bp_r_kept",        32'(r_bcd),     32'h007);

        // Reset during the 4th CONV cycle aborts the transaction.
        send(8'd55, 8'd66);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_q_bcd",     32'(q_bcd),     32'h0);
        check("abort_r_bcd",     32'(r_bcd),     32'h0);
        check("abort_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        check("abort_ready_after", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        send(8'd200, 8'd5);
        wait_out(lat);
        check("after_abort_lat", 32'(lat),   32'd8);
        check("after_abort_q",   32'(q_bcd), 32'h200);
        check("after_abort_r",   32'(r_bcd), 32'h005);
        @(negedge clk);

        // Full sweep against a decimal-digit reference.
        for (int i = 0; i < 256; i++) begin
            send(8'(i), 8'(255 - i));
            wait_out(lat);
            check($sformatf("sweep_q_%0d", i), 32'(q_bcd), 32'(ref_bcd(i)));
            check($sformatf("sweep_r_%0d", i), 32'(r_bcd), 32'(ref_bcd(255 - i)));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
